sar_adc_seq: RTL and testbench

- Sequencer for the mixed-signal SAR ADC instrument on the ms_adc_clk / ms_adc_rdy / ms_adc_cmp interface.
- On a conversion request it runs sample, then a binary search MSB to LSB. It drives the trial DAC code and the comparator strobe, and captures each comparator decision.
- It returns the result with a done pulse. Requests come from the JTAG test-data register or the core.
- It sits in the clk domain beside the JTAG TAP.

---
 rtl/sar_adc_seq.sv | 195 +++++++++++++++++++
 tb/tb_sar_adc_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_seq.sv
// sar_adc_seq
//   Sequencer for a successive-approximation ADC. A conversion request closes
//   the sample switch, then resolves the code from MSB to LSB. For each bit it
//   drives a trial DAC code, waits for settling, pulses the comparator strobe
//   and keeps or clears the bit according to the synchronised comparator
//   decision.
//
// Ports
//   clk, rstb        system clock, synchronous active-low reset
//   start, abort     conversion request (taken only in IDLE), synchronous abort
//   busy, done       conversion in progress, one-cycle completion pulse
//   result           last completed conversion code
//   err              sticky timeout flag, cleared by the next accepted start
//   ms_adc_sample    sample switch control
//   ms_adc_dac       trial code to the capacitive DAC
//   ms_adc_clk       comparator strobe (rising edge launches a comparison)
//   ms_adc_rdy/cmp   asynchronous comparator handshake and decision
module sar_adc_seq #(
    parameter int NBITS       = 10,
    parameter int SAMPLE_CYC  = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] result,
    output logic             err,
    output logic             ms_adc_sample,
    output logic [NBITS-1:0] ms_adc_dac,
    output logic             ms_adc_clk,
    input  logic             ms_adc_rdy,
    input  logic             ms_adc_cmp
);

    // One shared counter serves sample length, settle length (plus its
    // rdy-stuck extension) and the WAIT timeout.
    localparam int CMAX = (SAMPLE_CYC > SETTLE_CYC + TIMEOUT_CYC) ?
                          SAMPLE_CYC : SETTLE_CYC + TIMEOUT_CYC;
    localparam int CW = $clog2(CMAX + 1);
    localparam int IW = $clog2(NBITS);

    localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLE_CYC - 1);
    localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] SET_TMO   = CW'(SETTLE_CYC - 1 + TIMEOUT_CYC);
    localparam logic [CW-1:0] WAIT_TMO  = CW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] MSB_IDX   = IW'(NBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SAMPLE, S_SETTLE, S_STROBE, S_WAIT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    bit_q, bit_d;
    logic [NBITS-1:0] dac_q, dac_d;
    logic [NBITS-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             rdy_m_q, rdy_s_q, cmp_m_q, cmp_s_q;
    logic             timeout;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            dac_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            rdy_m_q  <= 1'b0;
            rdy_s_q  <= 1'b0;
            cmp_m_q  <= 1'b0;
            cmp_s_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            dac_q    <= dac_d;
            result_q <= result_d;
            err_q    <= err_d;
            rdy_m_q  <= ms_adc_rdy;
            rdy_s_q  <= rdy_m_q;
            cmp_m_q  <= ms_adc_cmp;
            cmp_s_q  <= cmp_m_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        dac_d    = dac_q;
        result_d = result_q;
        err_d    = err_q;
        timeout  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SAMPLE;
                    dac_d   = '0;
                    err_d   = 1'b0;
                    bit_d   = MSB_IDX;
                    cnt_d   = '0;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == SAMP_LAST) begin
                    dac_d[bit_q] = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                // Minimum settle time, then hold off until the comparator has
                // dropped its previous rdy so the next handshake is fresh.
                if (cnt_q >= SET_LAST) begin
                    if (!rdy_s_q) begin
                        state_d = S_STROBE;
                        cnt_d   = '0;
                    end else if (cnt_q == SET_TMO) begin
                        timeout = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STROBE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (rdy_s_q) begin
                    dac_d[bit_q] = cmp_s_q;
                    cnt_d        = '0;
                    if (bit_q != '0) begin
                        dac_d[bit_q - 1'b1] = 1'b1;
                        bit_d   = bit_q - 1'b1;
                        state_d = S_SETTLE;
                    end else begin
                        // Final code is latched here so result is valid in
                        // the same cycle done is high.
                        result_d = dac_d;
                        dac_d    = '0;
                        state_d  = S_DONE;
                    end
                end else if (cnt_q == WAIT_TMO) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timeout) begin
            err_d   = 1'b1;
            dac_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
        end

        // Abort overrides everything decided above, keeping result and err.
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            dac_d    = '0;
            cnt_d    = '0;
            bit_d    = bit_q;
            result_d = result_q;
            err_d    = err_q;
        end
    end

    assign busy          = (state_q == S_SAMPLE) || (state_q == S_SETTLE) ||
                           (state_q == S_STROBE) || (state_q == S_WAIT);
    assign done          = (state_q == S_DONE);
    assign ms_adc_sample = (state_q == S_SAMPLE);
    assign ms_adc_clk    = (state_q == S_STROBE) || (state_q == S_WAIT);
    assign ms_adc_dac    = dac_q;
    assign result        = result_q;
    assign err           = err_q;

endmodule

// File: tb/tb_sar_adc_seq.sv
module tb_sar_adc_seq;

    logic       clk = 1'b0;
    logic       rstb, start, abort;
    logic       busy, done, err, ms_adc_sample, ms_adc_clk;
    logic [9:0] result, ms_adc_dac;
    logic       ms_adc_rdy, ms_adc_cmp;

    int checks = 0;
    int errors = 0;

    // Comparator model: rdy rises W cycles after the strobe rises, drops
    // once the strobe falls; decision is input >= trial code.
    logic [9:0] vin = '0;
    logic       rdy_en = 1'b1;
    int         w_cyc = 1;
    int         mcnt = 0;
    logic [9:0] trial [0:15];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ms_adc_clk) mcnt <= mcnt + 1;
        else            mcnt <= 0;
    end
    assign ms_adc_rdy = rdy_en && (mcnt >= w_cyc);
    assign ms_adc_cmp = (vin >= ms_adc_dac);

    sar_adc_seq dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort),
        .busy(busy), .done(done), .result(result), .err(err),
        .ms_adc_sample(ms_adc_sample), .ms_adc_dac(ms_adc_dac),
        .ms_adc_clk(ms_adc_clk), .ms_adc_rdy(ms_adc_rdy), .ms_adc_cmp(ms_adc_cmp)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then observes cycles 1.. until done or a cycle budget.
    task automatic run_conv(input logic [9:0] v, output int dcyc, output int edges,
                            output logic [9:0] res, output int samp);
        logic prev_clk;
        vin = v; dcyc = 0; edges = 0; samp = 0; res = '0; prev_clk = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 1; cyc < 300; cyc++) begin
            if (ms_adc_clk && !prev_clk) begin
                if (edges < 16) trial[edges] = ms_adc_dac;
                edges++;
            end
            prev_clk = ms_adc_clk;
            if (ms_adc_sample) samp++;
            if (done) begin
                dcyc = cyc;
                res  = result;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rstb = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (3) tick;
        checks++;
        if ({busy, done, err, ms_adc_sample, ms_adc_clk, ms_adc_dac, result} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b err=%b dac=%h res=%h want all 0",
                     busy, done, err, ms_adc_dac, result);
        end
        rstb = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick;
            checks++;
            if ({busy, done, err, ms_adc_sample, ms_adc_clk, ms_adc_dac, result} !== '0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d got busy=%b done=%b dac=%h want all 0",
                         c, busy, done, ms_adc_dac);
            end
        end
    endtask

    task automatic test_midscale;
        int dc, ed, sp; logic [9:0] r;
        logic [9:0] exp_tr [0:4];
        exp_tr[0] = 10'h200; exp_tr[1] = 10'h300; exp_tr[2] = 10'h280;
        exp_tr[3] = 10'h2C0; exp_tr[4] = 10'h2A0;
        run_conv(10'h2A5, dc, ed, r, sp);
        checks++;
        if (dc !== 89) begin errors++; $display("FAIL mid_done_cycle got %0d want 89", dc); end
        checks++;
        if (r !== 10'h2A5) begin errors++; $display("FAIL mid_result got %h want 2a5", r); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", err); end
        checks++;
        if (sp !== 8) begin errors++; $display("FAIL mid_sample_len got %0d want 8", sp); end
        checks++;
        if (ed !== 10) begin errors++; $display("FAIL mid_edges got %0d want 10", ed); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (trial[k] !== exp_tr[k]) begin
                errors++;
                $display("FAIL mid_trial%0d got %h want %h", k, trial[k], exp_tr[k]);
            end
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_done got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_extremes;
        int dc, ed, sp; logic [9:0] r;
        run_conv(10'h3FF, dc, ed, r, sp);
        checks++;
        if (r !== 10'h3FF || dc !== 89) begin
            errors++; $display("FAIL ext_ones got res=%h cyc=%0d want 3ff 89", r, dc);
        end
        checks++;
        if (ed !== 10) begin errors++; $display("FAIL ext_ones_edges got %0d want 10", ed); end
        repeat (3) tick;
        run_conv(10'h000, dc, ed, r, sp);
        checks++;
        if (r !== 10'h000 || dc !== 89) begin
            errors++; $display("FAIL ext_zeros got res=%h cyc=%0d want 000 89", r, dc);
        end
        checks++;
        if (ed !== 10) begin errors++; $display("FAIL ext_zeros_edges got %0d want 10", ed); end
        repeat (3) tick;
    endtask

    task automatic test_timeout;
        int dc, ed, sp, err_cyc, ndone; logic [9:0] r;
        run_conv(10'h2A5, dc, ed, r, sp);
        repeat (3) tick;
        rdy_en = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        err_cyc = 0; ndone = 0;
        // MSB strobe is cycle 13; the flag is expected about 64 cycles later.
        for (int cyc = 1; cyc <= 120; cyc++) begin
            if (done) ndone++;
            if (cyc == 70) begin
                checks++;
                if (err !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL tmo_early got err=%b busy=%b want 0 1", err, busy);
                end
            end
            if (err && err_cyc == 0) err_cyc = cyc;
            tick;
        end
        checks++;
        if (err_cyc < 76 || err_cyc > 80) begin
            errors++; $display("FAIL tmo_err_cycle got %0d want 76..80", err_cyc);
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || ms_adc_clk !== 1'b0 || ms_adc_dac !== '0) begin
            errors++;
            $display("FAIL tmo_state got err=%b busy=%b clk=%b dac=%h want 1 0 0 000",
                     err, busy, ms_adc_clk, ms_adc_dac);
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL tmo_done got %0d pulses want 0", ndone); end
        checks++;
        if (result !== 10'h2A5) begin errors++; $display("FAIL tmo_result got %h want 2a5", result); end
        rdy_en = 1'b1;
        vin = 10'h155;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL tmo_clear got err=%b busy=%b want 0 1", err, busy);
        end
        for (int cyc = 1; cyc < 200 && !done; cyc++) tick;
        checks++;
        if (done !== 1'b1 || result !== 10'h155) begin
            errors++; $display("FAIL tmo_recover got done=%b res=%h want 1 155", done, result);
        end
        repeat (3) tick;
    endtask

    task automatic test_abort;
        int dc, ed, sp, ndone; logic [9:0] r;
        vin = 10'h0F0;
        ndone = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 1; cyc < 40; cyc++) begin
            if (done) ndone++;
            tick;
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || ms_adc_clk !== 1'b0 || ms_adc_dac !== '0 || done !== 1'b0 ||
            ms_adc_sample !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got busy=%b clk=%b dac=%h done=%b want 0 0 000 0",
                     busy, ms_adc_clk, ms_adc_dac, done);
        end
        checks++;
        if (result !== 10'h155 || ndone !== 0) begin
            errors++; $display("FAIL abort_result got res=%h dones=%0d want 155 0", result, ndone);
        end
        for (int cyc = 41; cyc < 45; cyc++) tick;
        run_conv(10'h0F0, dc, ed, r, sp);
        checks++;
        if (r !== 10'h0F0 || dc !== 89) begin
            errors++; $display("FAIL abort_restart got res=%h cyc=%0d want 0f0 89", r, dc);
        end
        repeat (3) tick;
    endtask

    task automatic test_back_to_back;
        int ndone, dcyc;
        vin = 10'h1C3;
        ndone = 0; dcyc = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 1; cyc <= 130; cyc++) begin
            if (done) begin ndone++; if (dcyc == 0) dcyc = cyc; end
            start = (cyc == 20);
            tick;
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1 || dcyc !== 89) begin
            errors++; $display("FAIL overlap got dones=%0d cyc=%0d want 1 89", ndone, dcyc);
        end
        checks++;
        if (result !== 10'h1C3) begin errors++; $display("FAIL overlap_result got %h want 1c3", result); end
    endtask

    task automatic test_reset_midop;
        int ndone;
        vin = 10'h3A1;
        ndone = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 1; cyc < 30; cyc++) tick;
        rstb = 1'b0;
        tick;
        checks++;
        if ({busy, done, err, ms_adc_sample, ms_adc_clk, ms_adc_dac, result} !== '0) begin
            errors++;
            $display("FAIL rst_midop got busy=%b clk=%b dac=%h res=%h want all 0",
                     busy, ms_adc_clk, ms_adc_dac, result);
        end
        rstb = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (done || busy) ndone++;
            tick;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL rst_no_done got %0d active cycles want 0", ndone); end
    endtask

    initial begin
        rstb = 1'b0; start = 1'b0; abort = 1'b0;
        test_reset;
        test_midscale;
        test_extremes;
        test_timeout;
        test_abort;
        test_back_to_back;
        test_reset_midop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
